// File: rtl/mult_arbiter.sv
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter sharing one sequential multiplier among
//               N_REQ requesters. Optional WAIT watchdog: MULT_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*16-1:0]   req_a,
    input  logic [N_REQ*16-1:0]   req_b,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_prod,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  mul_st,
    output logic [15:0]           mul_a,
    output logic [15:0]           mul_b,
    input  logic                  mul_idle,
    input  logic                  mul_done,
    input  logic [31:0]           mul_prod
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] g_q, g_d;
    logic [15:0]   a_q, a_d;
    logic [15:0]   b_q, b_d;
    logic [31:0]   prod_q, prod_d;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
`endif

    // Round-robin pick: scanning downward leaves the lowest offset from ptr.
    logic [PW-1:0] win;
    logic          found;
    logic [PW:0]   idx;

    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(N_REQ)) begin
                idx = idx - (PW+1)'(N_REQ);
            end
            if (req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
`ifdef MULT_ARB_TIMEOUT_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (mul_idle && found) begin
                    g_d     = win;
                    a_d     = req_a[16*win +: 16];
                    b_d     = req_b[16*win +: 16];
                    state_d = S_START;
                end
            end
            S_START: begin
`ifdef MULT_ARB_TIMEOUT_EN
                wdog_d  = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    prod_d  = mul_prod;
`ifdef MULT_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (wdog_q == WW'(TIMEOUT_CYC - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wdog_d  = wdog_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                ptr_d   = (g_q == PW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
`ifdef MULT_ARB_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    // Response outputs are gated by RESP so they read zero at all other times.
    assign busy      = (state_q != S_IDLE);
    assign mul_st    = (state_q == S_START);
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign rsp_valid = (state_q == S_RESP) ? (N_REQ'(1) << g_q) : '0;
    assign rsp_prod  = (state_q == S_RESP) ? prod_q : '0;
`ifdef MULT_ARB_TIMEOUT_EN
    assign rsp_err   = (state_q == S_RESP) ? err_q : 1'b0;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing one multiplicador instance (range 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, meaning the watchdog limit in cycles while waiting for Done.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous, active-low reset.
REQ-005 SHALL have port req, input, N_REQ, meaning per-requester operation request (level).
REQ-006 SHALL have port req_a, input, N_REQ*16, meaning per-requester multiplier operand, slice i = bits [16i+15:16i].
REQ-007 SHALL have port req_b, input, N_REQ*16, meaning per-requester multiplicand operand, same slicing.
REQ-008 SHALL have port rsp_valid, input-side, output, N_REQ, meaning one-hot, one-cycle completion strobe to the granted requester.
REQ-009 SHALL have port rsp_prod, output, 32, meaning the product, valid while any rsp_valid bit is high.
REQ-010 SHALL have port rsp_err, output, 1, meaning a timeout abort, qualified by rsp_valid.
REQ-011 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-012 SHALL have port mul_st, output, 1, meaning start pulse to the multiplier St.
REQ-013 SHALL have ports mul_a and mul_b, output, 16 each, meaning operands to Multiplicador and Multiplicando.
REQ-014 SHALL have port mul_idle, input, 1, meaning multiplier Idle.
REQ-015 SHALL have port mul_done, input, 1, meaning multiplier Done.
REQ-016 SHALL have port mul_prod, input, 32, meaning multiplier Produto.

Function
REQ-017 SHALL implement FSM states IDLE, START, WAIT and RESP.
REQ-018 IDLE SHALL sample req only when mul_idle=1; if any bit is set, it SHALL pick the winner round-robin starting at pointer ptr, latch that requester's operands into mul_a/mul_b, record grant index g, and go to START.
REQ-019 START SHALL assert mul_st for exactly one cycle and go to WAIT.
REQ-020 mul_a/mul_b SHALL stay constant from the START cycle until the FSM next leaves IDLE.
REQ-021 WAIT SHALL move to RESP on the first cycle mul_done=1, capturing mul_prod.
REQ-022 RESP SHALL last one cycle, drive rsp_valid[g]=1 with rsp_prod set to the captured product, set ptr=(g+1) mod N_REQ, and return to IDLE.
REQ-023 req SHALL be ignored outside IDLE; a req bit still high in the cycle after rsp_valid SHALL be treated as a new operation.
REQ-024 Requesters SHALL hold req and operands stable until their rsp_valid; changes while granted SHALL have no effect on the running operation.
REQ-025 Latency SHALL be 1 cycle from the IDLE grant to mul_st, and 1 cycle from the mul_done sample to rsp_valid.
REQ-026 With simultaneous requests, the lowest index at or after ptr SHALL win, and no requester SHALL wait more than N_REQ-1 operations.
REQ-027 mul_done seen outside WAIT SHALL be ignored.
REQ-028 rsp_prod and rsp_err SHALL be 0 whenever rsp_valid is all zero.

Reset
REQ-029 With rst=0, outputs SHALL clear immediately: mul_st=0, mul_a=mul_b=0, rsp_valid=0, rsp_prod=0, rsp_err=0, busy=0.
REQ-030 With rst=0, the FSM SHALL go to IDLE, ptr=0 and the watchdog=0.
REQ-031 A reset mid-operation SHALL abandon the operation with no rsp_valid issued, and a following mul_done SHALL be ignored.

Configuration
REQ-032 With macro MULT_ARB_TIMEOUT_EN defined, WAIT SHALL count cycles; when TIMEOUT_CYC cycles pass with no mul_done, it SHALL go to RESP with rsp_err=1 and rsp_prod=0.
REQ-033 The watchdog SHALL reset on entry to WAIT.
REQ-034 Without MULT_ARB_TIMEOUT_EN, WAIT SHALL be unbounded, rsp_err SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-035 Single request: req[0] with a=5000, b=6000 -> one mul_st pulse, then rsp_valid=0001 with rsp_prod=30000000 and rsp_err=0.
REQ-036 Maximum operands: req[1] with a=b=65535 -> rsp_prod=4294836225 on rsp_valid=0010; a=13, b=10 -> 130.
REQ-037 Contention: req[0] and req[2] held continuously with ptr=0 -> served in the order 0, 2, 0, 2, with exactly one mul_st per rsp_valid.
REQ-038 Fairness wrap: with ptr=3 after serving requester 2, req=1001 -> requester 3 is served first, then 0.
REQ-039 Reset mid-WAIT: rst low for 2 cycles while computing 3x15 -> outputs cleared asynchronously, no rsp_valid, next request 1x1 returns 1.
REQ-040 Timeout, with MULT_ARB_TIMEOUT_EN defined: mul_done stuck at 0 -> rsp_valid after 64 WAIT cycles with rsp_err=1 and rsp_prod=0; without the macro, busy stays 1 indefinitely.
